// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_WIDTH = 24;

    typedef logic [DIV_WIDTH-1:0] div_t;

    localparam div_t DEFAULT_DIV_VAL = '0;

    // Channel-select width: $clog2 of the channel count, never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, divisor register, divided clock and tick.
// Optional macro DIV_SHADOW_EN: divisor loads are held in a shadow register
// and applied at the next wrap so no period is ever cut short.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned      WIDTH       = DIV_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_VAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
`ifdef DIV_SHADOW_EN
    output logic             pending,
`endif
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] count;
    logic             wrap;

    // A disabled channel never wraps, so it simply holds its state.
    assign wrap = en && (count == div);

`ifdef DIV_SHADOW_EN

    logic [WIDTH-1:0] shadow;

    // Counter, divided clock and deferred divisor swap at the wrap boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= DEFAULT_DIV;
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                clk_out <= ~clk_out;
            end
            if (wrap) begin
                count <= '0;
            end else if (en) begin
                count <= count + WIDTH'(1);
            end
            // Swap only a value already pending; a load arriving on this
            // wrap waits for the next one.
            if (wrap && pending) begin
                div     <= shadow;
                pending <= 1'b0;
            end
            if (load) begin
                shadow  <= load_div;
                pending <= 1'b1;
            end
        end
    end

`else

    // Counter and divided clock; a load restarts the period immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= DEFAULT_DIV;
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                clk_out <= ~clk_out;
            end
            if (load) begin
                div   <= load_div;
                count <= '0;
            end else if (wrap) begin
                count <= '0;
            end else if (en) begin
                count <= count + WIDTH'(1);
            end
        end
    end

`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a valid/ready divisor port.
// Optional macro DIV_SHADOW_EN: glitch-free shadowed divisor loads; cfg_ready
// then reflects the pending flag of the addressed channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned      WIDTH       = DIV_WIDTH,
    parameter int unsigned      NUM_CH      = 4,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_VAL),
    localparam int unsigned     CH_W        = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic              cfg_fire;
    logic [NUM_CH-1:0] ch_load;

`ifdef DIV_SHADOW_EN

    localparam int unsigned PAD_W = 1 << CH_W;

    logic [NUM_CH-1:0] pending;
    logic [PAD_W-1:0]  pending_pad;

    // Unused select codes read as not-pending, so out-of-range loads are accepted.
    assign pending_pad = PAD_W'(pending);
    assign cfg_ready   = ~pending_pad[cfg_ch];

`else

    assign cfg_ready = 1'b1;

`endif

    assign cfg_fire = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        // Select codes at or above NUM_CH match no channel and are dropped.
        assign ch_load[i] = cfg_fire && (cfg_ch == CH_W'(i));

        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (ch_en[i]),
            .load     (ch_load[i]),
            .load_div (cfg_div),
`ifdef DIV_SHADOW_EN
            .pending  (pending[i]),
`endif
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule
